// File: rtl/lc_cmd_pkg.sv
// rtl/lc_cmd_pkg.sv - command codes, status bit indices and FSM states for the capture command responder
package lc_cmd_pkg;

    localparam logic [7:0] CMD_NOP           = 8'h00;
    localparam logic [7:0] CMD_START         = 8'h01;
    localparam logic [7:0] CMD_ABORT         = 8'h02;
    localparam logic [7:0] CMD_TRIG_CFG      = 8'h03;
    localparam logic [7:0] CMD_BUF_CFG       = 8'h04;
    localparam logic [7:0] CMD_READ_DATA     = 8'h05;
    localparam logic [7:0] CMD_READ_SIZE     = 8'h06;
    localparam logic [7:0] CMD_READ_TRIG     = 8'h07;
    localparam logic [7:0] CMD_ACK           = 8'h08;
    localparam logic [7:0] CMD_RESET         = 8'h09;
    localparam logic [7:0] CMD_READ_TRIG_ALT = 8'h10;

    localparam int STATUS_IDLE    = 0;
    localparam int STATUS_RUNNING = 1;
    localparam int STATUS_DONE    = 2;
    localparam int STATUS_ACK     = 3;
    localparam int STATUS_ERROR   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RD_WAIT,
        ST_ACK_WAIT
    } state_t;

endpackage

// File: rtl/capture_cmd_responder.sv
// rtl/capture_cmd_responder.sv - host-hub command decoder, config registers and ack handshake for the capture core
module capture_cmd_responder
    import lc_cmd_pkg::*;
#(
    parameter int          CHANNELS   = 16,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] DEF_PRE    = 32'd0,
    parameter logic [31:0] DEF_TOTAL  = 32'd0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          command,
    input  logic                commandStrobe,
    input  logic [7:0]          regIn0,
    input  logic [7:0]          regIn1,
    input  logic [7:0]          regIn2,
    input  logic [7:0]          regIn3,
    input  logic [7:0]          regIn4,
    input  logic [7:0]          regIn5,
    input  logic [7:0]          regIn6,
    input  logic [7:0]          regIn7,
    output logic [7:0]          regOut0,
    output logic [7:0]          regOut1,
    output logic [7:0]          regOut2,
    output logic [7:0]          regOut3,
    output logic [7:0]          regOut4,
    output logic [7:0]          regOut5,
    output logic [7:0]          regOut6,
    output logic [7:0]          regOut7,
    output logic [7:0]          status,
    input  logic                captureDone,
    input  logic [31:0]         traceSize,
    input  logic [31:0]         triggerSample,
    output logic                startPulse,
    output logic                abortPulse,
    output logic                softReset,
    output logic [31:0]         preTriggerCount,
    output logic [31:0]         totalSampleCount,
    output logic [CHANNELS-1:0] desiredPattern,
    output logic [CHANNELS-1:0] activeChannels,
    output logic [CHANNELS-1:0] dontCare,
    output logic [7:0]          edgeChannel,
    output logic                edgeType,
    output logic                edgeEnable,
    output logic                patternEnable,
    output logic                traceRdEn,
    output logic [31:0]         traceRdAddr,
    input  logic [CHANNELS-1:0] traceRdData
);

    localparam logic [31:0] CH_LIMIT     = 32'(CHANNELS);
    localparam logic [1:0]  RD_WAIT_INIT = 2'(RD_LATENCY - 1);

    state_t      state;
    logic        idle, ack, error, running, done;
    logic        capture_done_q;
    logic [1:0]  rd_cnt;
    logic [7:0]  reg_out [8];

    logic        accept, capture_rise, trig_bad, buf_bad, rd_bad;
    logic [31:0] arg_lo, arg_hi, rd_word;

    // Command acceptance and per-command argument checks, evaluated on the strobe cycle
    always_comb begin
        accept       = commandStrobe && (state == ST_IDLE) && (command != CMD_ACK);
        capture_rise = captureDone && !capture_done_q;
        arg_lo       = {regIn3, regIn2, regIn1, regIn0};
        arg_hi       = {regIn7, regIn6, regIn5, regIn4};
        trig_bad     = running || ({24'd0, regIn6} >= CH_LIMIT);
        buf_bad      = running || (arg_hi > arg_lo);
        rd_bad       = running || (traceRdAddr == traceSize);
        rd_word      = 32'(traceRdData);
    end

    // Status byte assembled from the registered flags
    always_comb begin
        status                 = '0;
        status[STATUS_IDLE]    = idle;
        status[STATUS_RUNNING] = running;
        status[STATUS_DONE]    = done;
        status[STATUS_ACK]     = ack;
        status[STATUS_ERROR]   = error;
    end

    assign regOut0 = reg_out[0];
    assign regOut1 = reg_out[1];
    assign regOut2 = reg_out[2];
    assign regOut3 = reg_out[3];
    assign regOut4 = reg_out[4];
    assign regOut5 = reg_out[5];
    assign regOut6 = reg_out[6];
    assign regOut7 = reg_out[7];

    // Handshake FSM plus all config, read-back and capture-state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_IDLE;
            idle             <= 1'b1;
            ack              <= 1'b0;
            error            <= 1'b0;
            running          <= 1'b0;
            done             <= 1'b0;
            capture_done_q   <= 1'b0;
            rd_cnt           <= '0;
            startPulse       <= 1'b0;
            abortPulse       <= 1'b0;
            softReset        <= 1'b0;
            traceRdEn        <= 1'b0;
            traceRdAddr      <= '0;
            preTriggerCount  <= DEF_PRE;
            totalSampleCount <= DEF_TOTAL;
            desiredPattern   <= '0;
            activeChannels   <= '0;
            dontCare         <= '0;
            edgeChannel      <= '0;
            edgeType         <= 1'b0;
            edgeEnable       <= 1'b0;
            patternEnable    <= 1'b0;
            for (int i = 0; i < 8; i++) reg_out[i] <= '0;
        end else begin
            startPulse     <= 1'b0;
            abortPulse     <= 1'b0;
            softReset      <= 1'b0;
            traceRdEn      <= 1'b0;
            capture_done_q <= captureDone;

            // A command accepted on the same edge overrides this below
            if (capture_rise) begin
                running <= 1'b0;
                done    <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EXEC;
                        idle  <= 1'b0;
                        error <= 1'b0;
                        case (command)
                            CMD_NOP: ;
                            CMD_START: begin
                                startPulse  <= 1'b1;
                                running     <= 1'b1;
                                done        <= 1'b0;
                                traceRdAddr <= '0;
                            end
                            CMD_ABORT: begin
                                abortPulse <= 1'b1;
                                running    <= 1'b0;
                                done       <= done;
                            end
                            CMD_TRIG_CFG: begin
                                if (trig_bad) begin
                                    error <= 1'b1;
                                end else begin
                                    desiredPattern <= CHANNELS'({regIn1, regIn0});
                                    activeChannels <= CHANNELS'({regIn3, regIn2});
                                    dontCare       <= CHANNELS'({regIn5, regIn4});
                                    edgeChannel    <= regIn6;
                                    {edgeType, edgeEnable, patternEnable} <= regIn7[2:0];
                                end
                            end
                            CMD_BUF_CFG: begin
                                if (buf_bad) begin
                                    error <= 1'b1;
                                end else begin
                                    preTriggerCount  <= arg_hi;
                                    totalSampleCount <= arg_lo;
                                end
                            end
                            CMD_READ_DATA: begin
                                if (rd_bad) error <= 1'b1;
                                else        traceRdEn <= 1'b1;
                            end
                            CMD_READ_SIZE: begin
                                {reg_out[3], reg_out[2], reg_out[1], reg_out[0]} <= traceSize;
                            end
                            CMD_READ_TRIG, CMD_READ_TRIG_ALT: begin
                                {reg_out[3], reg_out[2], reg_out[1], reg_out[0]} <= triggerSample;
                            end
                            CMD_RESET: begin
                                softReset        <= 1'b1;
                                running          <= 1'b0;
                                done             <= 1'b0;
                                traceRdAddr      <= '0;
                                preTriggerCount  <= DEF_PRE;
                                totalSampleCount <= DEF_TOTAL;
                                desiredPattern   <= '0;
                                activeChannels   <= '0;
                                dontCare         <= '0;
                                edgeChannel      <= '0;
                                edgeType         <= 1'b0;
                                edgeEnable       <= 1'b0;
                                patternEnable    <= 1'b0;
                                for (int i = 0; i < 8; i++) reg_out[i] <= '0;
                            end
                            default: error <= 1'b1;
                        endcase
                    end
                end
                ST_EXEC: begin
                    // The read request issued on acceptance decides whether to wait for RAM data
                    if (traceRdEn) begin
                        state  <= ST_RD_WAIT;
                        rd_cnt <= RD_WAIT_INIT;
                    end else begin
                        state <= ST_ACK_WAIT;
                        ack   <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_cnt == 2'd0) begin
                        reg_out[0] <= rd_word[7:0];
                        reg_out[1] <= rd_word[15:8];
                        if (CHANNELS > 16) begin
                            reg_out[2] <= rd_word[23:16];
                            reg_out[3] <= rd_word[31:24];
                        end
                        traceRdAddr <= traceRdAddr + 32'd1;
                        state       <= ST_ACK_WAIT;
                        ack         <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end
                end
                ST_ACK_WAIT: begin
                    if (commandStrobe) begin
                        if (command == CMD_ACK) begin
                            state <= ST_IDLE;
                            ack   <= 1'b0;
                            idle  <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ack   <= 1'b0;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_cmd_responder.sv
// tb/tb_capture_cmd_responder.sv - self-checking bench for capture_cmd_responder
module tb_capture_cmd_responder;
    import lc_cmd_pkg::*;

    localparam int CH     = 16;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic [7:0]    command;
    logic          commandStrobe;
    logic [7:0]    rin [8];
    logic [7:0]    regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7;
    logic [7:0]    status;
    logic          captureDone;
    logic [31:0]   traceSize, triggerSample;
    logic          startPulse, abortPulse, softReset;
    logic [31:0]   preTriggerCount, totalSampleCount;
    logic [CH-1:0] desiredPattern, activeChannels, dontCare;
    logic [7:0]    edgeChannel;
    logic          edgeType, edgeEnable, patternEnable;
    logic          traceRdEn;
    logic [31:0]   traceRdAddr;
    logic [CH-1:0] traceRdData;

    capture_cmd_responder #(.CHANNELS(CH), .RD_LATENCY(RD_LAT), .DEF_PRE(32'd0), .DEF_TOTAL(32'd0)) dut (
        .clk(clk), .resetn(resetn), .command(command), .commandStrobe(commandStrobe),
        .regIn0(rin[0]), .regIn1(rin[1]), .regIn2(rin[2]), .regIn3(rin[3]),
        .regIn4(rin[4]), .regIn5(rin[5]), .regIn6(rin[6]), .regIn7(rin[7]),
        .regOut0(regOut0), .regOut1(regOut1), .regOut2(regOut2), .regOut3(regOut3),
        .regOut4(regOut4), .regOut5(regOut5), .regOut6(regOut6), .regOut7(regOut7),
        .status(status), .captureDone(captureDone), .traceSize(traceSize), .triggerSample(triggerSample),
        .startPulse(startPulse), .abortPulse(abortPulse), .softReset(softReset),
        .preTriggerCount(preTriggerCount), .totalSampleCount(totalSampleCount),
        .desiredPattern(desiredPattern), .activeChannels(activeChannels), .dontCare(dontCare),
        .edgeChannel(edgeChannel), .edgeType(edgeType), .edgeEnable(edgeEnable), .patternEnable(patternEnable),
        .traceRdEn(traceRdEn), .traceRdAddr(traceRdAddr), .traceRdData(traceRdData)
    );

    always #5 clk = ~clk;

    // Trace RAM: data appears RD_LAT clocks after the request is sampled
    logic [CH-1:0] mem [8];
    logic [CH-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= traceRdEn ? mem[traceRdAddr[2:0]] : 16'hDEAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign traceRdData = rd_pipe[RD_LAT-1];

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    logic [31:0]   m_pre, m_tot, m_addr;
    logic [CH-1:0] m_pat, m_act, m_dc;
    logic [7:0]    m_ech;
    logic [2:0]    m_emode;
    logic          m_run, m_done, m_err;
    logic [7:0]    m_out [8];

    logic [7:0] codes [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h09, 8'h55, 8'hF0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_tot = 0; m_addr = 0; m_pat = 0; m_act = 0; m_dc = 0;
        m_ech = 0; m_emode = 0; m_run = 0; m_done = 0;
        for (int i = 0; i < 8; i++) m_out[i] = 0;
    endtask

    // Applies one accepted command to the model; rd reports whether a RAM read is expected
    task automatic model_cmd(input logic [7:0] c, output bit rd);
        logic [31:0] lo, hi, d;
        lo = {rin[3], rin[2], rin[1], rin[0]};
        hi = {rin[7], rin[6], rin[5], rin[4]};
        rd = 0;
        m_err = 0;
        case (c)
            8'h00: ;
            8'h01: begin m_run = 1; m_done = 0; m_addr = 0; end
            8'h02: m_run = 0;
            8'h03: if (m_run || int'(rin[6]) >= CH) m_err = 1;
                   else begin
                       m_pat = {rin[1], rin[0]}; m_act = {rin[3], rin[2]}; m_dc = {rin[5], rin[4]};
                       m_ech = rin[6]; m_emode = rin[7][2:0];
                   end
            8'h04: if (m_run || hi > lo) m_err = 1; else begin m_pre = hi; m_tot = lo; end
            8'h05: if (m_run || m_addr == traceSize) m_err = 1;
                   else begin
                       rd = 1;
                       d = 32'(mem[m_addr % 8]);
                       m_out[0] = d[7:0]; m_out[1] = d[15:8];
                       m_addr = m_addr + 1;
                   end
            8'h06: begin m_out[0] = traceSize[7:0]; m_out[1] = traceSize[15:8]; m_out[2] = traceSize[23:16]; m_out[3] = traceSize[31:24]; end
            8'h07, 8'h10: begin m_out[0] = triggerSample[7:0]; m_out[1] = triggerSample[15:8]; m_out[2] = triggerSample[23:16]; m_out[3] = triggerSample[31:24]; end
            8'h09: model_reset();
            default: m_err = 1;
        endcase
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pre"}, preTriggerCount, m_pre);
        chk({tag, "_total"}, totalSampleCount, m_tot);
        chk({tag, "_trig"}, {desiredPattern, activeChannels, dontCare}, {m_pat, m_act, m_dc});
        chk({tag, "_edge"}, {edgeChannel, edgeType, edgeEnable, patternEnable}, {m_ech, m_emode});
        chk({tag, "_regout"}, {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0},
            {m_out[7], m_out[6], m_out[5], m_out[4], m_out[3], m_out[2], m_out[1], m_out[0]});
        chk({tag, "_addr"}, traceRdAddr, m_addr);
    endtask

    task automatic strobe(input logic [7:0] c);
        @(negedge clk);
        command = c;
        commandStrobe = 1'b1;
        @(negedge clk);
        commandStrobe = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int exp_n);
        int n;
        n = 1;
        while (status[STATUS_ACK] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, exp_n);
    endtask

    task automatic send_ack(input string tag);
        strobe(CMD_ACK);
        chk({tag, "_ack_release"}, status, {3'b0, m_err, 1'b0, m_done, m_run, 1'b1});
    endtask

    task automatic do_cmd_noack(input string tag, input logic [7:0] c, input logic cap);
        bit rd;
        logic [31:0] a0;
        a0 = m_addr;
        if (cap && !captureDone && c != CMD_ABORT) begin m_run = 0; m_done = 1; end
        model_cmd(c, rd);
        @(negedge clk);
        command = c;
        commandStrobe = 1'b1;
        captureDone = cap;
        @(negedge clk);
        commandStrobe = 1'b0;
        chk({tag, "_pulses"}, {startPulse, abortPulse, softReset, traceRdEn},
            {c == CMD_START, c == CMD_ABORT, c == CMD_RESET, rd});
        if (rd) chk({tag, "_rdaddr"}, traceRdAddr, a0);
        wait_ack(tag, rd ? 2 + RD_LAT : 2);
        chk({tag, "_status"}, status, {3'b0, m_err, 1'b1, m_done, m_run, 1'b0});
        chk({tag, "_pulses_off"}, {startPulse, abortPulse, softReset, traceRdEn}, 4'b0);
        check_state(tag);
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] c, input logic cap);
        do_cmd_noack(tag, c, cap);
        send_ack(tag);
    endtask

    task automatic set_capture(input logic v);
        @(negedge clk);
        if (v && !captureDone) begin m_run = 0; m_done = 1; end
        captureDone = v;
        @(negedge clk);
        chk("capture_status", status, {3'b0, m_err, 1'b0, m_done, m_run, 1'b1});
    endtask

    task automatic clear_args();
        for (int i = 0; i < 8; i++) rin[i] = 8'h00;
    endtask

    task automatic rand_args();
        for (int i = 0; i < 8; i++) rin[i] = 8'($urandom);
    endtask

    task automatic set_word(input int base, input logic [31:0] v);
        rin[base] = v[7:0]; rin[base+1] = v[15:8]; rin[base+2] = v[23:16]; rin[base+3] = v[31:24];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; command = 8'h00; commandStrobe = 1'b0; captureDone = 1'b0;
        traceSize = 0; triggerSample = 0;
        clear_args();
        for (int i = 0; i < 8; i++) mem[i] = CH'($urandom);
        model_reset();
        m_err = 0;
        repeat (3) @(negedge clk);
        chk("rst_status", status, 8'h01);
        chk("rst_pulses", {startPulse, abortPulse, softReset, traceRdEn}, 4'b0);
        check_state("rst");
        resetn = 1'b1;

        clear_args(); rin[0] = 8'h6E; rin[4] = 8'h14;
        do_cmd("buf_cfg", CMD_BUF_CFG, 1'b0);
        chk("buf_cfg_pre20", preTriggerCount, 32'd20);
        chk("buf_cfg_total110", totalSampleCount, 32'd110);

        clear_args(); rin[0] = 8'h9D; rin[1] = 8'hCC; rin[2] = 8'hFF; rin[3] = 8'hFF; rin[6] = 8'd2; rin[7] = 8'd3;
        do_cmd("trig_cfg", CMD_TRIG_CFG, 1'b0);
        chk("trig_cfg_fields", {desiredPattern, activeChannels, edgeChannel, edgeType, edgeEnable, patternEnable},
            {16'hCC9D, 16'hFFFF, 8'd2, 3'b011});

        for (int i = 0; i < 4; i++) begin
            rand_args(); rin[6] = 8'($urandom_range(0, 24));
            do_cmd("rnd_trig", CMD_TRIG_CFG, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            rand_args(); set_word(4, $urandom_range(0, 300)); set_word(0, $urandom_range(0, 300));
            do_cmd("rnd_buf", CMD_BUF_CFG, 1'b0);
        end

        do_cmd("start", CMD_START, 1'b0);
        clear_args(); rin[0] = 8'h20; rin[4] = 8'h01;
        do_cmd("buf_running", CMD_BUF_CFG, 1'b0);
        set_capture(1'b1);
        set_capture(1'b0);

        clear_args(); set_word(4, 32'd200); set_word(0, 32'd100);
        do_cmd("buf_pre_gt_total", CMD_BUF_CFG, 1'b0);

        traceSize = 32'd3;
        clear_args();
        for (int i = 0; i < 3; i++) do_cmd("read_data", CMD_READ_DATA, 1'b0);
        do_cmd("read_past_end", CMD_READ_DATA, 1'b0);

        traceSize = $urandom;
        do_cmd("read_size", CMD_READ_SIZE, 1'b0);
        triggerSample = $urandom;
        do_cmd("read_trig07", CMD_READ_TRIG, 1'b0);
        triggerSample = $urandom;
        do_cmd("read_trig10", CMD_READ_TRIG_ALT, 1'b0);
        do_cmd("bad_code55", 8'h55, 1'b0);

        strobe(CMD_ACK);
        for (int i = 0; i < 3; i++) begin
            chk("ack_in_idle", status, {3'b0, m_err, 1'b0, m_done, m_run, 1'b1});
            @(negedge clk);
        end

        do_cmd_noack("nop_hold", CMD_NOP, 1'b0);
        strobe(CMD_START);
        m_err = 1;
        chk("start_in_ackwait_pulse", startPulse, 1'b0);
        chk("start_in_ackwait_status", status, {3'b0, m_err, 1'b1, m_done, m_run, 1'b0});
        send_ack("start_in_ackwait");

        do_cmd("start2", CMD_START, 1'b0);
        do_cmd("abort_with_capture", CMD_ABORT, 1'b1);
        chk("abort_with_capture_done", status[STATUS_DONE], 1'b0);
        set_capture(1'b0);

        do_cmd("soft_reset", CMD_RESET, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rand_args(); rin[6] = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) set_capture(~captureDone);
            traceSize = $urandom_range(0, 10);
            triggerSample = $urandom;
            do_cmd("soak", codes[$urandom_range(0, 11)], captureDone);
        end
        set_capture(1'b0);

        traceSize = 32'd8;
        do_cmd("pre_async_read", CMD_READ_DATA, 1'b0);
        do_cmd_noack("async_hold", CMD_NOP, 1'b0);
        #3 resetn = 1'b0;
        #1;
        model_reset();
        m_err = 0;
        chk("async_rst_status", status, 8'h01);
        check_state("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        do_cmd("post_rst_size", CMD_READ_SIZE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
